// File: rtl/udp_payload_packer.sv
// Frame buffer between the UDP source mux and the UDP/MAC transmit core: stores 24-bit words
// per frame, commits or rolls back whole frames, then replays each as an MSB-first byte stream.
module udp_payload_packer #(
  parameter int unsigned FIFO_AW   = 10,
  parameter int unsigned MAX_WORDS = 488,
  parameter int unsigned LQ_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] app_tx_data,
  input  logic        app_tx_data_valid,
  input  logic [15:0] app_tx_data_length,
  input  logic        app_tx_data_done,
  output logic        udp_tx_req,
  output logic [15:0] udp_tx_byte_len,
  input  logic        udp_tx_ack,
  output logic [7:0]  udp_tx_byte,
  output logic        udp_tx_byte_valid,
  input  logic        udp_tx_byte_ready,
  output logic        udp_tx_last,
  output logic [15:0] frame_drop_cnt,
  output logic        len_mismatch,
  output logic        busy
);
  localparam int unsigned LqAw = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned LqCw = $clog2(LQ_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StLoad, StSend} state_e;

  logic [23:0]      mem [2**FIFO_AW];
  logic [15:0]      lq [LQ_DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, frame_start_ptr, wr_ptr_inc;
  logic [23:0]      rd_data, shift_reg;
  logic [15:0]      cur_words, final_words, words_left;
  logic             bad, fifo_full, wr_ok, frame_bad, lq_full, push, drop, pop, rd_en, xfer;
  logic [LqAw-1:0]  lq_wr, lq_rd;
  logic [LqCw-1:0]  lq_cnt;
  logic [1:0]       byte_idx;
  state_e           state;

  function automatic logic [LqAw-1:0] lq_next(input logic [LqAw-1:0] idx);
    return (idx == LqAw'(LQ_DEPTH - 1)) ? '0 : idx + LqAw'(1);
  endfunction

  // The level seen by the full check includes uncommitted words of the frame being received.
  always_comb begin
    fifo_full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    wr_ok       = app_tx_data_valid && !fifo_full && (cur_words < 16'(MAX_WORDS));
    wr_ptr_inc  = wr_ptr + {{FIFO_AW{1'b0}}, wr_ok};
    final_words = cur_words + {15'd0, wr_ok};
    frame_bad   = bad || (app_tx_data_valid && !wr_ok);
    lq_full     = (lq_cnt == LqCw'(LQ_DEPTH));
    push        = app_tx_data_done && (final_words != 16'd0) && !frame_bad && !lq_full;
    drop        = app_tx_data_done && (final_words != 16'd0) && (frame_bad || lq_full);
  end

  // Reads run one word ahead of the shift register so word boundaries cost no bubble.
  always_comb begin
    xfer  = udp_tx_byte_valid && udp_tx_byte_ready;
    rd_en = 1'b0;
    pop   = 1'b0;
    case (state)
      StReq:  rd_en = udp_tx_ack;
      StLoad: rd_en = (words_left > 16'd1);
      StSend: begin
        if (xfer && (byte_idx == 2'd2)) begin
          pop   = (words_left == 16'd1);
          rd_en = (words_left > 16'd2);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= app_tx_data;
    if (rd_en) rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
    if (push && !reset) lq[lq_wr] <= final_words;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      frame_start_ptr <= '0;
      cur_words       <= '0;
      bad             <= 1'b0;
      lq_wr           <= '0;
      lq_rd           <= '0;
      lq_cnt          <= '0;
      frame_drop_cnt  <= '0;
      len_mismatch    <= 1'b0;
    end else begin
      wr_ptr <= drop ? frame_start_ptr : wr_ptr_inc;
      if (rd_en) rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
      if (push) begin
        frame_start_ptr <= wr_ptr_inc;
        lq_wr           <= lq_next(lq_wr);
      end
      if (pop) lq_rd <= lq_next(lq_rd);
      if (push && !pop) lq_cnt <= lq_cnt + LqCw'(1);
      else if (!push && pop) lq_cnt <= lq_cnt - LqCw'(1);
      if (drop && (frame_drop_cnt != 16'hFFFF)) frame_drop_cnt <= frame_drop_cnt + 16'd1;
      len_mismatch <= app_tx_data_done && (final_words != app_tx_data_length);
      if (app_tx_data_done) begin
        cur_words <= '0;
        bad       <= 1'b0;
      end else begin
        cur_words <= final_words;
        bad       <= frame_bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= StIdle;
      udp_tx_req        <= 1'b0;
      udp_tx_byte_len   <= '0;
      udp_tx_byte       <= '0;
      udp_tx_byte_valid <= 1'b0;
      udp_tx_last       <= 1'b0;
      shift_reg         <= '0;
      byte_idx          <= '0;
      words_left        <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (lq_cnt != '0) begin
            words_left      <= lq[lq_rd];
            udp_tx_byte_len <= lq[lq_rd] * 16'd3;
            udp_tx_req      <= 1'b1;
            state           <= StReq;
          end
        end
        StReq: begin
          if (udp_tx_ack) begin
            udp_tx_req <= 1'b0;
            state      <= StLoad;
          end
        end
        StLoad: begin
          shift_reg         <= rd_data;
          byte_idx          <= 2'd0;
          udp_tx_byte       <= rd_data[23:16];
          udp_tx_byte_valid <= 1'b1;
          udp_tx_last       <= 1'b0;
          state             <= StSend;
        end
        StSend: begin
          if (xfer) begin
            case (byte_idx)
              2'd0: begin
                byte_idx    <= 2'd1;
                udp_tx_byte <= shift_reg[15:8];
              end
              2'd1: begin
                byte_idx    <= 2'd2;
                udp_tx_byte <= shift_reg[7:0];
                udp_tx_last <= (words_left == 16'd1);
              end
              default: begin
                words_left  <= words_left - 16'd1;
                udp_tx_last <= 1'b0;
                if (words_left == 16'd1) begin
                  udp_tx_byte_valid <= 1'b0;
                  udp_tx_byte       <= '0;
                  state             <= StIdle;
                end else begin
                  shift_reg   <= rd_data;
                  byte_idx    <= 2'd0;
                  udp_tx_byte <= rd_data[23:16];
                end
              end
            endcase
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule

// File: tb/tb_udp_payload_packer.sv
// Bench for udp_payload_packer: directed vector table, hold/reset sequences and random frame
// pairs scored against a frame-level model (words -> bytes, drops, length mismatches).
module tb_udp_payload_packer;
  localparam int MaxWords = 488;
  localparam int LqDepth  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] app_tx_data = '0;
  logic        app_tx_data_valid = 1'b0;
  logic [15:0] app_tx_data_length = '0;
  logic        app_tx_data_done = 1'b0;
  logic        udp_tx_req, udp_tx_byte_valid, udp_tx_last, len_mismatch, busy;
  logic        udp_tx_ack = 1'b0;
  logic        udp_tx_byte_ready = 1'b0;
  logic [15:0] udp_tx_byte_len, frame_drop_cnt;
  logic [7:0]  udp_tx_byte;

  always #5 clk = ~clk;

  udp_payload_packer #(.FIFO_AW(10), .MAX_WORDS(MaxWords), .LQ_DEPTH(LqDepth)) dut (
    .clk(clk), .reset(reset),
    .app_tx_data(app_tx_data), .app_tx_data_valid(app_tx_data_valid),
    .app_tx_data_length(app_tx_data_length), .app_tx_data_done(app_tx_data_done),
    .udp_tx_req(udp_tx_req), .udp_tx_byte_len(udp_tx_byte_len), .udp_tx_ack(udp_tx_ack),
    .udp_tx_byte(udp_tx_byte), .udp_tx_byte_valid(udp_tx_byte_valid),
    .udp_tx_byte_ready(udp_tx_byte_ready), .udp_tx_last(udp_tx_last),
    .frame_drop_cnt(frame_drop_cnt), .len_mismatch(len_mismatch), .busy(busy)
  );

  int          checks = 0, errors = 0;
  int          cyc = 0, ready_mode = 0;
  bit          ack_en = 1'b1;
  logic [3:0]  rdy_pat = 4'b1001;
  logic [8:0]  got_q[$], exp_q[$];
  int          got_cycle[$];
  logic [15:0] got_len[$], exp_len[$];
  int          got_frames = 0, exp_frames = 0, got_mm = 0, exp_mm = 0, exp_drop = 0;
  bit          prev_stall = 1'b0;
  logic [8:0]  prev_out = '0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_len = '0;

  typedef struct {
    int          n;
    bit          tail;
    logic [15:0] len;
    int          rmode;
    logic [15:0] exp_blen;
    int          drop_inc;
    int          mm_inc;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] word_at(input logic [23:0] base, input int i);
    return base + 24'(i) * 24'h333333;
  endfunction

  task automatic push_exp(input int n, input logic [23:0] base);
    logic [23:0] w;
    for (int i = 0; i < n; i++) begin
      w = word_at(base, i);
      exp_q.push_back({1'b0, w[23:16]});
      exp_q.push_back({1'b0, w[15:8]});
      exp_q.push_back({i == n - 1, w[7:0]});
    end
    exp_frames++;
  endtask

  // Frame-level reference: oversize frames and frames arriving with the queue full are lost.
  task automatic model_frame(input int n, input logic [15:0] len, input logic [23:0] base);
    int fin;
    fin = (n > MaxWords) ? MaxWords : n;
    if (32'(fin) != 32'(len)) exp_mm++;
    if (fin != 0) begin
      if (n > MaxWords || (exp_frames - got_frames) >= LqDepth) exp_drop++;
      else begin
        push_exp(n, base);
        exp_len.push_back(16'(3 * n));
      end
    end
  endtask

  task automatic send_frame(input int n, input bit tail, input logic [15:0] len,
                            input logic [23:0] base, input int max_gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      app_tx_data        = word_at(base, i);
      app_tx_data_valid  = 1'b1;
      app_tx_data_done   = tail && (i == n - 1);
      app_tx_data_length = len;
      if (i < n - 1) begin
        repeat ($urandom_range(0, max_gap)) begin
          @(negedge clk);
          app_tx_data_valid = 1'b0;
        end
      end
    end
    if (!tail || n == 0) begin
      @(negedge clk);
      app_tx_data_valid  = 1'b0;
      app_tx_data_done   = 1'b1;
      app_tx_data_length = len;
    end
    @(negedge clk);
    app_tx_data_valid = 1'b0;
    app_tx_data_done  = 1'b0;
  endtask

  task automatic drain(input string tag, input bit gapless);
    int t;
    t = 0;
    while ((got_frames != exp_frames || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " drain"}, 32'(t < 5000), 1);
    repeat (8) @(negedge clk);
    check({tag, " nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s last,byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " nreq"}, got_len.size(), exp_len.size());
    for (int i = 0; i < got_len.size() && i < exp_len.size(); i++)
      check($sformatf("%s byte_len%0d", tag, i), 32'(got_len[i]), 32'(exp_len[i]));
    if (gapless && got_q.size() > 0)
      check({tag, " gapless"}, got_cycle[got_cycle.size() - 1] - got_cycle[0],
            got_q.size() - 1);
    check({tag, " len_mismatch count"}, got_mm, exp_mm);
    check({tag, " frame_drop_cnt"}, 32'(frame_drop_cnt), exp_drop);
    got_q.delete(); exp_q.delete(); got_cycle.delete(); got_len.delete(); exp_len.delete();
    got_frames = 0;
    exp_frames = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " req"}, 32'(udp_tx_req), 0);
    check({tag, " byte_len"}, 32'(udp_tx_byte_len), 0);
    check({tag, " valid"}, 32'(udp_tx_byte_valid), 0);
    check({tag, " byte"}, 32'(udp_tx_byte), 0);
    check({tag, " last"}, 32'(udp_tx_last), 0);
    check({tag, " drop_cnt"}, 32'(frame_drop_cnt), 0);
    check({tag, " len_mismatch"}, 32'(len_mismatch), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  // Sink/ack driver and observer; ready is set before the transfer is judged.
  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      0:       udp_tx_byte_ready = 1'b1;
      1:       udp_tx_byte_ready = rdy_pat[cyc % 4];
      default: udp_tx_byte_ready = ($urandom_range(0, 3) != 0);
    endcase
    udp_tx_ack = ack_en && udp_tx_req && !udp_tx_ack;
    if (prev_stall) begin
      check("stall valid held", 32'(udp_tx_byte_valid), 1);
      check("stall last,byte held", 32'({udp_tx_last, udp_tx_byte}), 32'(prev_out));
    end
    prev_stall = udp_tx_byte_valid && !udp_tx_byte_ready;
    prev_out   = {udp_tx_last, udp_tx_byte};
    if (udp_tx_req && prev_req) check("byte_len stable", 32'(udp_tx_byte_len), 32'(prev_len));
    if (udp_tx_req && !prev_req) begin
      got_len.push_back(udp_tx_byte_len);
      check("busy during req", 32'(busy), 1);
    end
    prev_req = udp_tx_req;
    prev_len = udp_tx_byte_len;
    if (len_mismatch) got_mm++;
    if (udp_tx_byte_valid && udp_tx_byte_ready) begin
      got_q.push_back({udp_tx_last, udp_tx_byte});
      got_cycle.push_back(cyc);
      if (udp_tx_last) got_frames++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, off;
    bit tail;
    logic [15:0] len;
    logic [23:0] base;

    vecs[0] = '{4,   1'b0, 16'd4,   0, 16'd12, 0, 0};
    vecs[1] = '{4,   1'b0, 16'd4,   1, 16'd12, 0, 0};
    vecs[2] = '{3,   1'b1, 16'd2,   0, 16'd9,  0, 1};
    vecs[3] = '{489, 1'b0, 16'd489, 0, 16'd0,  1, 1};
    vecs[4] = '{2,   1'b0, 16'd2,   0, 16'd6,  0, 0};
    vecs[5] = '{0,   1'b0, 16'd0,   0, 16'd0,  0, 0};
    vecs[6] = '{1,   1'b1, 16'd1,   2, 16'd3,  0, 0};

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      ready_mode = vecs[k].rmode;
      exp_drop  += vecs[k].drop_inc;
      exp_mm    += vecs[k].mm_inc;
      if (vecs[k].exp_blen != 16'd0) begin
        push_exp(vecs[k].n, 24'h112233);
        exp_len.push_back(vecs[k].exp_blen);
      end
      send_frame(vecs[k].n, vecs[k].tail, vecs[k].len, 24'h112233, 0);
      drain($sformatf("vec%0d", k), (vecs[k].rmode == 0) && (vecs[k].exp_blen != 16'd0));
    end

    // Ack withheld: two frames fill the length queue, the third is dropped.
    ack_en     = 1'b0;
    ready_mode = 0;
    for (int f = 0; f < 3; f++) begin
      base = 24'h010203 + 24'(f) * 24'h101010;
      model_frame(1, 16'd1, base);
      send_frame(1, 1'b0, 16'd1, base, 0);
    end
    repeat (10) @(negedge clk);
    check("hold frame_drop_cnt", 32'(frame_drop_cnt), exp_drop);
    check("hold no bytes", got_q.size(), 0);
    ack_en = 1'b1;
    drain("hold", 1'b0);

    for (int r = 0; r < 25; r++) begin
      ready_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
      for (int f = 0; f < 2; f++) begin
        n = ($urandom_range(0, 19) == 0) ? MaxWords + int'($urandom_range(1, 3))
                                         : int'($urandom_range(0, 8));
        off = int'($urandom_range(0, 4));
        len = 16'(n);
        if (off == 3) len = len + 16'd1;
        else if (off == 4) len = len - 16'd1;
        tail = 1'($urandom_range(0, 1));
        base = 24'($urandom);
        model_frame(n, len, base);
        send_frame(n, tail, len, base, 2);
      end
      drain($sformatf("rnd%0d", r), 1'b0);
    end

    // Reset in the middle of a packet abandons it; the next frame starts clean.
    ready_mode = 0;
    model_frame(10, 16'd10, 24'h0A0B0C);
    send_frame(10, 1'b0, 16'd10, 24'h0A0B0C, 0);
    t = 0;
    while (got_q.size() < 5 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("pre-reset progress", 32'(got_q.size() >= 5), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("midsend reset");
    got_q.delete(); exp_q.delete(); got_cycle.delete(); got_len.delete(); exp_len.delete();
    got_frames = 0;
    exp_frames = 0;
    got_mm     = 0;
    exp_mm     = 0;
    exp_drop   = 0;
    model_frame(3, 16'd3, 24'hC0FFEE);
    send_frame(3, 1'b0, 16'd3, 24'hC0FFEE, 0);
    drain("post-reset", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
